mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
- Memory stage of the pipelined RV32I core. Sits between the execute-stage ALU/address output and the load-extract logic.
- Turns a load/store request into synchronous-BRAM data-memory controls: word address, byte write enables and lane-shifted store data.
- Registers load metadata for one cycle so it lines up with the BRAM read data. Load metadata is extract-select and address low bits.
- Owns the memory-mapped cycle and retired-instruction counters.

Parameters:
- DMEM_AW, 14, data-memory word-address width.
- MMIO_CYC, 32'h8000_0010, cycle-counter read address.
- MMIO_INST, 32'h8000_0014, instruction-counter read address.
- MMIO_CRST, 32'h8000_0018, counter-reset write address.

Ports:
- clk  in  1  core clock
- rst  in  1  reset, asynchronous, active-high
- stall  in  1  pipeline hold; no new access issued, registered outputs hold
- mem_rd  in  1  load in memory stage this cycle
- mem_wr  in  1  store in memory stage this cycle
- funct3  in  3  instruction funct3
- addr  in  32  effective address from ALU
- wdata  in  32  rs2 store data (unshifted)
- inst_retired  in  1  one instruction retires this cycle
- dmem_en  out  1  BRAM enable
- dmem_addr  out  DMEM_AW  word address, equal to addr[DMEM_AW+1:2]
- dmem_we  out  4  byte write enables
- dmem_din  out  32  lane-aligned store data
- ldx_sel_q  out  3  registered load-extract select
- addr_lo_q  out  2  registered addr[1:0]
- mmio_sel_q  out  1  registered; 1 means load data comes from mmio_rdata_q, not BRAM
- mmio_rdata_q  out  32  registered MMIO read data
- misaligned_q  out  1  one-cycle pulse for a misaligned access
- cycle_cnt  out  32  cycle counter
- inst_cnt  out  32  retired-instruction counter

Behaviour:
- Address decode:
  - addr[31]=0 is a DMEM access; addr[31]=1 is an MMIO access.
  - MMIO accesses never assert dmem_we or dmem_en.
- Misaligned access is defined as either case below. Misaligned stores are suppressed (dmem_we=0). Misaligned loads still read, and extract result is don't-care.
  - Halfword access with addr[0]=1.
  - Word access with addr[1:0]!=0.
- Store path (combinational):
  - Issued when mem_wr & !stall & !rst & DMEM & aligned.
  - sb: dmem_we=4'b0001<<addr[1:0]; dmem_din={4{wdata[7:0]}}.
  - sh: dmem_we=4'b0011<<addr[1:0]; dmem_din={2{wdata[15:0]}}.
  - sw: dmem_we=4'b1111; dmem_din=wdata.
  - Otherwise dmem_we=0 and dmem_din=wdata.
- dmem_en=(mem_rd|mem_wr) & !stall & DMEM.
- Load path: on a clock edge with !stall, register the load metadata.
  - ldx_sel_q maps funct3 as: lb 000→100, lh 001→010, lw 010→000, lbu 100→011, lhu 101→001. Any other value maps to 000.
  - addr_lo_q<=addr[1:0].
  - mmio_sel_q<=mem_rd & addr[31].
  - mmio_rdata_q takes one of three values:
    - cycle_cnt (pre-increment value) for a read of MMIO_CYC.
    - inst_cnt for a read of MMIO_INST.
    - 0 for any other address.
- Read latency is 1 cycle: BRAM dout and the *_q outputs are valid together in the next cycle.
- When stall=1, all *_q registers hold, except misaligned_q, which clears.
- misaligned_q<=(mem_rd|mem_wr) & !stall & misaligned. It is high for exactly one cycle per offending access.
- Counters:
  - cycle_cnt increments every cycle, including stalled cycles.
  - inst_cnt increments when inst_retired=1.
  - Both wrap from 32'hFFFF_FFFF to 0.
- A store to MMIO_CRST (mem_wr & !stall) sets both counters to 0 on that edge. Reset beats a simultaneous increment.
- Reset (async, rst=1): all registered outputs and counters go to 0 immediately. Combinational dmem_we is forced to 0 while rst=1. An access in flight at reset is dropped.
- When mem_rd and mem_wr are both set, the store takes effect, and mmio_sel_q still follows mem_rd.

Decomposition:
- Shared constants go in the core constants header:
  - funct3 load/store codes.
  - ldx_sel encodings (LDX_LW, LDX_LHU, LDX_LH, LDX_LBU, LDX_LB).
  - MMIO address constants.
- One natural sub-module, mmio_counters: the cycle/instret counters, the reset-on-write logic and the read mux.

Test Plan:
- sb at addr=0x0000_0006, wdata=0x1234_56AB → dmem_we=4'b0100, dmem_din=0xABAB_ABAB, dmem_addr=1, misaligned_q=0 next cycle.
- lh at addr=0x0000_0102 → next cycle ldx_sel_q=3'b010, addr_lo_q=2, mmio_sel_q=0; with BRAM dout=0x8001_0000, the downstream extract returns 0xFFFF_8001.
- sw at addr=0x0000_0101 → dmem_we=0 and misaligned_q=1 for exactly one cycle. lw at 0x0000_0104 → misaligned_q=0.
- After reset, hold 100 cycles with inst_retired high on 40 of them; lw at 0x8000_0010 and 0x8000_0014 → mmio_sel_q=1, mmio_rdata_q=the pre-increment cycle_cnt and inst_cnt=40.
- sw to 0x8000_0018 while inst_retired=1 → both counters read 0 after the edge and resume at 1.
- stall=1 with mem_wr=1 → dmem_we=0 and *_q hold. Assert rst mid-access → all outputs 0 asynchronously, and the counters restart from 0.

Source files
------------

// File: rtl/mem_access_stage_pkg.sv
// Shared constants for the memory stage of the RV32I core.
// Holds the funct3 load/store codes, the load-extract select encodings
// consumed by the downstream extract logic, the MMIO counter addresses,
// and two small decode helpers used by the stage.
package mem_access_stage_pkg;

  // funct3 codes for loads and stores (access size in bits [1:0]).
  localparam logic [2:0] F3_B  = 3'b000;  // lb / sb
  localparam logic [2:0] F3_H  = 3'b001;  // lh / sh
  localparam logic [2:0] F3_W  = 3'b010;  // lw / sw
  localparam logic [2:0] F3_BU = 3'b100;  // lbu
  localparam logic [2:0] F3_HU = 3'b101;  // lhu

  // Load-extract select encodings.
  localparam logic [2:0] LDX_LW  = 3'b000;
  localparam logic [2:0] LDX_LHU = 3'b001;
  localparam logic [2:0] LDX_LH  = 3'b010;
  localparam logic [2:0] LDX_LBU = 3'b011;
  localparam logic [2:0] LDX_LB  = 3'b100;

  // Memory-mapped counter addresses.
  localparam logic [31:0] MMIO_CYC_ADDR  = 32'h8000_0010;
  localparam logic [31:0] MMIO_INST_ADDR = 32'h8000_0014;
  localparam logic [31:0] MMIO_CRST_ADDR = 32'h8000_0018;

  // Map a load funct3 onto the extract select; unknown codes read a full word.
  function automatic logic [2:0] ldx_sel_of(input logic [2:0] f3);
    case (f3)
      F3_B:    ldx_sel_of = LDX_LB;
      F3_H:    ldx_sel_of = LDX_LH;
      F3_W:    ldx_sel_of = LDX_LW;
      F3_BU:   ldx_sel_of = LDX_LBU;
      F3_HU:   ldx_sel_of = LDX_LHU;
      default: ldx_sel_of = LDX_LW;
    endcase
  endfunction

  // Halfwords need addr[0]=0, words need addr[1:0]=0; bytes are always aligned.
  function automatic logic misaligned_of(input logic [2:0] f3, input logic [1:0] lo);
    case (f3[1:0])
      2'b01:   misaligned_of = lo[0];
      2'b10:   misaligned_of = (lo != 2'b00);
      default: misaligned_of = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_stage_mmio_counters.sv
// Cycle and retired-instruction counters with their MMIO read mux.
// Ports:
//   clk, rst       core clock, async active-high reset
//   stall          pipeline hold (blocks the counter-reset store)
//   mem_rd/mem_wr  load / store in the memory stage
//   addr           effective address
//   inst_retired   one instruction retires this cycle
//   rdata          combinational read data for the addressed counter (0 otherwise)
//   cycle_cnt      free-running cycle counter (counts stalled cycles too)
//   inst_cnt       retired-instruction counter
module mem_access_stage_mmio_counters
  import mem_access_stage_pkg::*;
#(
  parameter logic [31:0] MMIO_CYC  = MMIO_CYC_ADDR,
  parameter logic [31:0] MMIO_INST = MMIO_INST_ADDR,
  parameter logic [31:0] MMIO_CRST = MMIO_CRST_ADDR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic [31:0] addr,
  input  logic        inst_retired,
  output logic [31:0] rdata,
  output logic [31:0] cycle_cnt,
  output logic [31:0] inst_cnt
);

  logic crst_hit;

  // A store to the reset address clears both counters; it wins over the
  // increment on the same edge.
  assign crst_hit = mem_wr & ~stall & (addr == MMIO_CRST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_cnt <= '0;
      inst_cnt  <= '0;
    end else if (crst_hit) begin
      cycle_cnt <= '0;
      inst_cnt  <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (inst_retired) inst_cnt <= inst_cnt + 32'd1;
    end
  end

  // Reads return the current (pre-increment) counter value.
  always_comb begin
    rdata = '0;
    if (mem_rd && addr == MMIO_CYC)       rdata = cycle_cnt;
    else if (mem_rd && addr == MMIO_INST) rdata = inst_cnt;
  end

endmodule

// File: rtl/mem_access_stage.sv
// Memory stage of the pipelined RV32I core.
// Turns a load/store request into synchronous-BRAM controls, registers the
// load metadata for one cycle so it lines up with BRAM read data, and owns
// the memory-mapped cycle / retired-instruction counters.
// Ports:
//   clk, rst        core clock, async active-high reset
//   stall           pipeline hold: no access issued, *_q hold (misaligned_q clears)
//   mem_rd, mem_wr  load / store this cycle
//   funct3          access size / signedness
//   addr, wdata     effective address, unshifted rs2 data
//   inst_retired    retire strobe for the instruction counter
//   dmem_en, dmem_addr, dmem_we, dmem_din   BRAM controls
//   ldx_sel_q, addr_lo_q, mmio_sel_q, mmio_rdata_q   load metadata, valid with BRAM dout
//   misaligned_q    one-cycle pulse per misaligned access
//   cycle_cnt, inst_cnt   counters
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int          DMEM_AW   = 14,
  parameter logic [31:0] MMIO_CYC  = MMIO_CYC_ADDR,
  parameter logic [31:0] MMIO_INST = MMIO_INST_ADDR,
  parameter logic [31:0] MMIO_CRST = MMIO_CRST_ADDR
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               mem_rd,
  input  logic               mem_wr,
  input  logic [2:0]         funct3,
  input  logic [31:0]        addr,
  input  logic [31:0]        wdata,
  input  logic               inst_retired,
  output logic               dmem_en,
  output logic [DMEM_AW-1:0] dmem_addr,
  output logic [3:0]         dmem_we,
  output logic [31:0]        dmem_din,
  output logic [2:0]         ldx_sel_q,
  output logic [1:0]         addr_lo_q,
  output logic               mmio_sel_q,
  output logic [31:0]        mmio_rdata_q,
  output logic               misaligned_q,
  output logic [31:0]        cycle_cnt,
  output logic [31:0]        inst_cnt
);

  logic        is_dmem;
  logic        misaligned;
  logic        access;
  logic [31:0] mmio_rdata;

  assign is_dmem    = ~addr[31];
  assign misaligned = misaligned_of(funct3, addr[1:0]);
  assign access     = (mem_rd | mem_wr) & ~stall;

  // Reset drops any access in flight, so the enable is gated as well.
  assign dmem_en   = access & is_dmem & ~rst;
  assign dmem_addr = addr[DMEM_AW+1:2];

  // Store lane steering: data is replicated across lanes and the byte
  // enables pick the lanes actually written.
  always_comb begin
    dmem_we  = 4'b0000;
    dmem_din = wdata;
    if (mem_wr && !stall && !rst && is_dmem && !misaligned) begin
      case (funct3)
        F3_B: begin
          dmem_we  = 4'b0001 << addr[1:0];
          dmem_din = {4{wdata[7:0]}};
        end
        F3_H: begin
          dmem_we  = 4'b0011 << addr[1:0];
          dmem_din = {2{wdata[15:0]}};
        end
        F3_W: begin
          dmem_we  = 4'b1111;
          dmem_din = wdata;
        end
        default: begin
          dmem_we  = 4'b0000;
          dmem_din = wdata;
        end
      endcase
    end
  end

  // Load metadata: captured every non-stalled edge, consumed one cycle later
  // together with BRAM dout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ldx_sel_q    <= LDX_LW;
      addr_lo_q    <= 2'b00;
      mmio_sel_q   <= 1'b0;
      mmio_rdata_q <= '0;
      misaligned_q <= 1'b0;
    end else begin
      misaligned_q <= access & misaligned;
      if (!stall) begin
        ldx_sel_q    <= ldx_sel_of(funct3);
        addr_lo_q    <= addr[1:0];
        mmio_sel_q   <= mem_rd & addr[31];
        mmio_rdata_q <= mmio_rdata;
      end
    end
  end

  mem_access_stage_mmio_counters #(
    .MMIO_CYC  (MMIO_CYC),
    .MMIO_INST (MMIO_INST),
    .MMIO_CRST (MMIO_CRST)
  ) u_counters (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .mem_rd       (mem_rd),
    .mem_wr       (mem_wr),
    .addr         (addr),
    .inst_retired (inst_retired),
    .rdata        (mmio_rdata),
    .cycle_cnt    (cycle_cnt),
    .inst_cnt     (inst_cnt)
  );

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        mem_rd;
  logic        mem_wr;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        inst_retired;
  logic        dmem_en;
  logic [13:0] dmem_addr;
  logic [3:0]  dmem_we;
  logic [31:0] dmem_din;
  logic [2:0]  ldx_sel_q;
  logic [1:0]  addr_lo_q;
  logic        mmio_sel_q;
  logic [31:0] mmio_rdata_q;
  logic        misaligned_q;
  logic [31:0] cycle_cnt;
  logic [31:0] inst_cnt;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_cyc;

  mem_access_stage dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .mem_rd       (mem_rd),
    .mem_wr       (mem_wr),
    .funct3       (funct3),
    .addr         (addr),
    .wdata        (wdata),
    .inst_retired (inst_retired),
    .dmem_en      (dmem_en),
    .dmem_addr    (dmem_addr),
    .dmem_we      (dmem_we),
    .dmem_din     (dmem_din),
    .ldx_sel_q    (ldx_sel_q),
    .addr_lo_q    (addr_lo_q),
    .mmio_sel_q   (mmio_sel_q),
    .mmio_rdata_q (mmio_rdata_q),
    .misaligned_q (misaligned_q),
    .cycle_cnt    (cycle_cnt),
    .inst_cnt     (inst_cnt)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
    exp_cyc = exp_cyc + 32'd1;
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d);
    mem_rd = rd;
    mem_wr = wr;
    funct3 = f3;
    addr   = a;
    wdata  = d;
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference load extract applied to BRAM dout using the registered metadata.
  function automatic logic [31:0] extract(input logic [31:0] dout, input logic [2:0] sel,
                                          input logic [1:0] lo);
    logic [31:0] sh;
    sh = dout >> (8 * lo);
    case (sel)
      3'b001:  extract = {16'h0, sh[15:0]};
      3'b010:  extract = {{16{sh[15]}}, sh[15:0]};
      3'b011:  extract = {24'h0, sh[7:0]};
      3'b100:  extract = {{24{sh[7]}}, sh[7:0]};
      default: extract = dout;
    endcase
  endfunction

  initial begin
    rst = 1'b1; stall = 1'b0; inst_retired = 1'b0;
    exp_cyc = '0;
    drive(1'b0, 1'b1, 3'b010, 32'h0000_0000, 32'hDEAD_BEEF);
    @(posedge clk); @(posedge clk); #1;
    // Reset state, with a store presented during reset
    check("rst_we", {28'h0, dmem_we}, 32'h0);
    check("rst_en", {31'h0, dmem_en}, 32'h0);
    check("rst_cyc", cycle_cnt, 32'h0);
    check("rst_inst", inst_cnt, 32'h0);
    check("rst_ldx", {29'h0, ldx_sel_q}, 32'h0);
    check("rst_mmio_sel", {31'h0, mmio_sel_q}, 32'h0);
    check("rst_misal", {31'h0, misaligned_q}, 32'h0);
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    rst = 1'b0;
    exp_cyc = '0;

    // 100 cycles, 40 retirements
    for (int i = 0; i < 100; i++) begin
      inst_retired = (i < 40);
      step();
    end
    inst_retired = 1'b0;
    check("cyc_100", cycle_cnt, 32'd100);
    check("inst_40", inst_cnt, 32'd40);

    // MMIO counter reads
    drive(1'b1, 1'b0, 3'b010, 32'h8000_0010, 32'h0);
    check("mmio_en", {31'h0, dmem_en}, 32'h0);
    step();
    check("mmio_cyc_sel", {31'h0, mmio_sel_q}, 32'h1);
    check("mmio_cyc_rd", mmio_rdata_q, 32'd100);
    check("mmio_cyc_now", cycle_cnt, 32'd101);
    drive(1'b1, 1'b0, 3'b010, 32'h8000_0014, 32'h0);
    step();
    check("mmio_inst_rd", mmio_rdata_q, 32'd40);
    drive(1'b1, 1'b0, 3'b010, 32'h8000_0020, 32'h0);
    step();
    check("mmio_other_rd", mmio_rdata_q, 32'h0);

    // Counter reset store, with a simultaneous retirement
    drive(1'b0, 1'b1, 3'b010, 32'h8000_0018, 32'h0);
    inst_retired = 1'b1;
    #1;
    check("crst_we", {28'h0, dmem_we}, 32'h0);
    check("crst_en", {31'h0, dmem_en}, 32'h0);
    step();
    exp_cyc = '0;
    check("crst_cyc", cycle_cnt, 32'h0);
    check("crst_inst", inst_cnt, 32'h0);
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    step();
    inst_retired = 1'b0;
    check("resume_cyc", cycle_cnt, 32'd1);
    check("resume_inst", inst_cnt, 32'd1);

    // Stores
    drive(1'b0, 1'b1, 3'b000, 32'h0000_0006, 32'h1234_56AB);
    check("sb_we", {28'h0, dmem_we}, 32'h4);
    check("sb_din", dmem_din, 32'hABAB_ABAB);
    check("sb_addr", {18'h0, dmem_addr}, 32'h1);
    check("sb_en", {31'h0, dmem_en}, 32'h1);
    step();
    check("sb_misal", {31'h0, misaligned_q}, 32'h0);
    drive(1'b0, 1'b1, 3'b001, 32'h0000_0002, 32'h1234_56AB);
    check("sh_we", {28'h0, dmem_we}, 32'hC);
    check("sh_din", dmem_din, 32'h56AB_56AB);
    drive(1'b0, 1'b1, 3'b010, 32'h0000_0010, 32'h1234_56AB);
    check("sw_we", {28'h0, dmem_we}, 32'hF);
    check("sw_din", dmem_din, 32'h1234_56AB);
    check("sw_addr", {18'h0, dmem_addr}, 32'h4);
    drive(1'b0, 1'b1, 3'b010, 32'h8000_0000, 32'h1234_56AB);
    check("sw_mmio_we", {28'h0, dmem_we}, 32'h0);
    step();

    // Loads
    drive(1'b1, 1'b0, 3'b001, 32'h0000_0102, 32'h0);
    check("lh_we", {28'h0, dmem_we}, 32'h0);
    check("lh_en", {31'h0, dmem_en}, 32'h1);
    check("lh_addr", {18'h0, dmem_addr}, 32'h40);
    step();
    check("lh_ldx", {29'h0, ldx_sel_q}, 32'h2);
    check("lh_lo", {30'h0, addr_lo_q}, 32'h2);
    check("lh_mmio_sel", {31'h0, mmio_sel_q}, 32'h0);
    check("lh_extract", extract(32'h8001_0000, ldx_sel_q, addr_lo_q), 32'hFFFF_8001);
    drive(1'b1, 1'b0, 3'b000, 32'h0000_0003, 32'h0);
    step();
    check("lb_ldx", {29'h0, ldx_sel_q}, 32'h4);
    check("lb_lo", {30'h0, addr_lo_q}, 32'h3);
    drive(1'b1, 1'b0, 3'b100, 32'h0000_0001, 32'h0);
    step();
    check("lbu_ldx", {29'h0, ldx_sel_q}, 32'h3);
    drive(1'b1, 1'b0, 3'b101, 32'h0000_0002, 32'h0);
    step();
    check("lhu_ldx", {29'h0, ldx_sel_q}, 32'h1);
    drive(1'b1, 1'b0, 3'b011, 32'h0000_0000, 32'h0);
    step();
    check("f3_011_ldx", {29'h0, ldx_sel_q}, 32'h0);

    // Misaligned accesses
    drive(1'b0, 1'b1, 3'b010, 32'h0000_0101, 32'hCAFE_F00D);
    check("sw_misal_we", {28'h0, dmem_we}, 32'h0);
    step();
    check("sw_misal_q1", {31'h0, misaligned_q}, 32'h1);
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    step();
    check("sw_misal_q2", {31'h0, misaligned_q}, 32'h0);
    drive(1'b1, 1'b0, 3'b010, 32'h0000_0104, 32'h0);
    step();
    check("lw_aligned_q", {31'h0, misaligned_q}, 32'h0);
    drive(1'b0, 1'b1, 3'b001, 32'h0000_0003, 32'h1111_2222);
    check("sh_misal_we", {28'h0, dmem_we}, 32'h0);
    step();
    check("sh_misal_q", {31'h0, misaligned_q}, 32'h1);

    // Stall: misaligned lh first so misaligned_q is high going in
    drive(1'b1, 1'b0, 3'b001, 32'h0000_0201, 32'h0);
    check("lh_misal_en", {31'h0, dmem_en}, 32'h1);
    step();
    check("pre_stall_misal", {31'h0, misaligned_q}, 32'h1);
    check("pre_stall_ldx", {29'h0, ldx_sel_q}, 32'h2);
    stall = 1'b1;
    drive(1'b1, 1'b1, 3'b000, 32'h8000_0010, 32'h5555_5555);
    check("stall_we", {28'h0, dmem_we}, 32'h0);
    drive(1'b1, 1'b1, 3'b000, 32'h0000_0004, 32'h5555_5555);
    check("stall_dmem_we", {28'h0, dmem_we}, 32'h0);
    check("stall_en", {31'h0, dmem_en}, 32'h0);
    step();
    check("stall_ldx_hold", {29'h0, ldx_sel_q}, 32'h2);
    check("stall_lo_hold", {30'h0, addr_lo_q}, 32'h1);
    check("stall_sel_hold", {31'h0, mmio_sel_q}, 32'h0);
    check("stall_misal_clr", {31'h0, misaligned_q}, 32'h0);
    check("stall_cyc", cycle_cnt, exp_cyc);
    stall = 1'b0;

    // Reset in the middle of an access
    drive(1'b0, 1'b1, 3'b010, 32'h0000_0020, 32'h0BAD_F00D);
    check("pre_rst_we", {28'h0, dmem_we}, 32'hF);
    rst = 1'b1;
    #1;
    check("arst_we", {28'h0, dmem_we}, 32'h0);
    check("arst_en", {31'h0, dmem_en}, 32'h0);
    check("arst_ldx", {29'h0, ldx_sel_q}, 32'h0);
    check("arst_lo", {30'h0, addr_lo_q}, 32'h0);
    check("arst_cyc", cycle_cnt, 32'h0);
    check("arst_inst", inst_cnt, 32'h0);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    rst = 1'b0;
    exp_cyc = '0;
    step(); step(); step();
    check("post_rst_cyc", cycle_cnt, 32'd3);
    check("post_rst_inst", inst_cnt, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
